// File: rtl/wb_arbiter_3x1_pkg.sv
// Shared encodings for the 3:1 write-back arbiter: mux selects, FSM states and
// the default data width.
package wb_arbiter_3x1_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

endpackage

// File: rtl/mux_3x1_32.sv
// Shared 3:1 result mux; select 11 is never driven by the arbiter and yields zero.
module MUX_3X1_32
    import wb_arbiter_3x1_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [1:0]       i_sel,
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic [WIDTH-1:0] i_d2,
    output logic [WIDTH-1:0] o_y
);

    always_comb begin
        o_y = '0;
        case (i_sel)
            SEL_A:   o_y = i_d0;
            SEL_B:   o_y = i_d1;
            SEL_C:   o_y = i_d2;
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/wb_arbiter_3x1_rr_pick3.sv
// Round-robin pick among three eligible requesters; the search starts at the
// requester after the last grant and wraps C->A.
module rr_pick3
    import wb_arbiter_3x1_pkg::*;
(
    input  logic [2:0] i_eligible,
    input  logic [1:0] i_last_grant,
    output logic [2:0] o_winner,
    output logic [1:0] o_sel
);

    always_comb begin
        o_winner = 3'b000;
        o_sel    = SEL_A;
        case (i_last_grant)
            SEL_A: begin
                if (i_eligible[1])      begin o_winner = 3'b010; o_sel = SEL_B; end
                else if (i_eligible[2]) begin o_winner = 3'b100; o_sel = SEL_C; end
                else if (i_eligible[0]) begin o_winner = 3'b001; o_sel = SEL_A; end
            end
            SEL_B: begin
                if (i_eligible[2])      begin o_winner = 3'b100; o_sel = SEL_C; end
                else if (i_eligible[0]) begin o_winner = 3'b001; o_sel = SEL_A; end
                else if (i_eligible[1]) begin o_winner = 3'b010; o_sel = SEL_B; end
            end
            default: begin
                if (i_eligible[0])      begin o_winner = 3'b001; o_sel = SEL_A; end
                else if (i_eligible[1]) begin o_winner = 3'b010; o_sel = SEL_B; end
                else if (i_eligible[2]) begin o_winner = 3'b100; o_sel = SEL_C; end
            end
        endcase
    end

endmodule

// File: rtl/wb_arbiter_3x1.sv
// Round-robin arbiter in front of the write-back path: captures one requester's
// word per load into a valid/ready output register and acks the winner.
module wb_arbiter_3x1
    import wb_arbiter_3x1_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] data_c,
    output logic [2:0]       ack,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      xfer_cnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_ack;
    logic [1:0]       r_sel;
    logic [1:0]       r_last;
    logic [WIDTH-1:0] r_data;
    logic [15:0]      r_cnt;

    logic [2:0]       w_elig;
    logic [2:0]       w_win;
    logic [1:0]       w_pick_sel;
    logic [1:0]       w_sel_nxt;
    logic [WIDTH-1:0] w_mux;
    logic             w_load;
    logic             w_xfer;

    // A requester being acked this cycle is masked so a held req is not captured twice.
    assign w_elig = req & ~r_ack;
    assign w_xfer = (r_state == ST_FULL) && out_ready;

    rr_pick3 u_pick (
        .i_eligible   (w_elig),
        .i_last_grant (r_last),
        .o_winner     (w_win),
        .o_sel        (w_pick_sel)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_sel_nxt   = r_sel;
        case (r_state)
            ST_IDLE: begin
                if (|w_elig) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    if (|w_elig) w_load = 1'b1;
                    else         w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_load) w_sel_nxt = w_pick_sel;
    end

    MUX_3X1_32 #(.WIDTH(WIDTH)) u_mux (
        .i_sel (w_sel_nxt),
        .i_d0  (data_a),
        .i_d1  (data_b),
        .i_d2  (data_c),
        .o_y   (w_mux)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // last_grant resets to C so that A is searched first after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack  <= 3'b000;
            r_sel  <= SEL_A;
            r_last <= SEL_C;
            r_data <= '0;
            r_cnt  <= 16'd0;
        end else begin
            r_ack <= w_load ? w_win : 3'b000;
            if (w_load) begin
                r_sel  <= w_sel_nxt;
                r_last <= w_sel_nxt;
                r_data <= w_mux;
            end
            if (w_xfer) r_cnt <= r_cnt + 16'd1;
        end
    end

    assign ack       = r_ack;
    assign sel       = r_sel;
    assign out_data  = r_data;
    assign out_valid = (r_state == ST_FULL);
    assign xfer_cnt  = r_cnt;

endmodule
